// File: rtl/mips_cpu_bus_store_unit_if.sv
// Avalon-style write bus between the store unit (master) and memory (slave).
//   address     : word address driven by the master
//   write       : write strobe, held with the data until waitrequest is low
//   writedata   : little-endian aligned store data
//   byteenable  : active byte lanes, bit i covers writedata[8i+7:8i]
//   waitrequest : memory stall; the master holds the transfer while it is high
interface mips_cpu_bus_store_unit_if;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;

    modport master (
        output address,
        output write,
        output writedata,
        output byteenable,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  byteenable,
        output waitrequest
    );
endinterface

// File: rtl/mips_cpu_bus_store_unit.sv
// Store-side bus master of the bus-based MIPS CPU. Takes an SB/SH/SW/SWL/SWR
// request, aligns rt into a little-endian word with matching byteenable and
// runs one write transaction, reporting done, addr_err or timeout.
//   clk, reset  : clock and asynchronous active-high reset
//   start       : store request, only looked at in IDLE
//   store_type  : 1=SB 2=SH 3=SW 4=SWL 5=SWR, anything else is invalid
//   eff_addr    : byte effective address
//   rt_data     : register value to store
//   busy        : request in flight (WRITE, DONE or ERR)
//   done        : one-cycle pulse, write accepted by memory
//   addr_err    : one-cycle pulse, misaligned SH/SW or invalid type
//   timeout     : one-cycle pulse, write abandoned after MAX_WAIT stalls
//   bus         : write bus master port
module mips_cpu_bus_store_unit #(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  store_type,
    input  logic [31:0] eff_addr,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic        addr_err,
    output logic        timeout,
    mips_cpu_bus_store_unit_if.master bus
);
    localparam logic [2:0] ST_SB  = 3'd1;
    localparam logic [2:0] ST_SH  = 3'd2;
    localparam logic [2:0] ST_SW  = 3'd3;
    localparam logic [2:0] ST_SWL = 3'd4;
    localparam logic [2:0] ST_SWR = 3'd5;

    typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;

    state_t      state_q;
    logic        busy_q, done_q, addr_err_q, timeout_q, write_q;
    logic [31:0] address_q, writedata_q, wait_q;
    logic [3:0]  byteenable_q;

    logic        req_ok_d;
    logic [3:0]  be_d;
    logic [31:0] wd_d;

    function automatic logic req_ok(input logic [2:0] t, input logic [1:0] o);
        case (t)
            ST_SB, ST_SWL, ST_SWR: req_ok = 1'b1;
            ST_SH:                 req_ok = ~o[0];
            ST_SW:                 req_ok = (o == 2'd0);
            default:               req_ok = 1'b0;
        endcase
    endfunction

    // SWL fills the low lanes up to o (the MSBs of rt), SWR fills lanes from
    // o upward (the LSBs of rt).
    function automatic logic [3:0] lane_be(input logic [2:0] t, input logic [1:0] o);
        case (t)
            ST_SB:   lane_be = 4'b0001 << o;
            ST_SH:   lane_be = o[1] ? 4'b1100 : 4'b0011;
            ST_SW:   lane_be = 4'b1111;
            ST_SWL:  lane_be = 4'b1111 >> (2'd3 - o);
            ST_SWR:  lane_be = 4'b1111 << o;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wd(input logic [2:0] t, input logic [1:0] o,
                                            input logic [31:0] rt);
        case (t)
            ST_SB:   lane_wd = {4{rt[7:0]}};
            ST_SH:   lane_wd = {2{rt[15:0]}};
            ST_SW:   lane_wd = rt;
            ST_SWL:  lane_wd = rt >> {2'd3 - o, 3'b000};
            ST_SWR:  lane_wd = rt << {o, 3'b000};
            default: lane_wd = 32'd0;
        endcase
    endfunction

    always_comb begin
        req_ok_d = req_ok(store_type, eff_addr[1:0]);
        be_d     = lane_be(store_type, eff_addr[1:0]);
        wd_d     = lane_wd(store_type, eff_addr[1:0], rt_data);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= 32'd0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'd0;
            wait_q       <= 32'd0;
        end else begin
            // status outputs are single-cycle pulses
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (!req_ok_d) begin
                            state_q    <= ERR;
                            addr_err_q <= 1'b1;
                        end else begin
                            state_q      <= WRITE;
                            write_q      <= 1'b1;
                            address_q    <= {eff_addr[31:2], 2'b00};
                            writedata_q  <= wd_d;
                            byteenable_q <= be_d;
                            wait_q       <= 32'd0;
                        end
                    end
                end
                WRITE: begin
                    if (!bus.waitrequest) begin
                        state_q <= DONE;
                        write_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                        if (MAX_WAIT != 0 && (wait_q + 32'd1) == MAX_WAIT) begin
                            state_q   <= IDLE;
                            write_q   <= 1'b0;
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                DONE, ERR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign addr_err       = addr_err_q;
    assign timeout        = timeout_q;
    assign bus.address    = address_q;
    assign bus.write      = write_q;
    assign bus.writedata  = writedata_q;
    assign bus.byteenable = byteenable_q;
endmodule

// File: tb/tb_mips_cpu_bus_store_unit.sv
module tb_mips_cpu_bus_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [2:0]  st = 3'd0;
    logic [31:0] ea = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        busy0, done0, aerr0, tmo0;
    logic        busy1, done1, aerr1, tmo1;

    int n_chk = 0;
    int n_fail = 0;

    mips_cpu_bus_store_unit_if bus0 ();
    mips_cpu_bus_store_unit_if bus1 ();

    mips_cpu_bus_store_unit #(.MAX_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .store_type(st),
        .eff_addr(ea), .rt_data(rt), .busy(busy0), .done(done0),
        .addr_err(aerr0), .timeout(tmo0), .bus(bus0.master)
    );

    mips_cpu_bus_store_unit #(.MAX_WAIT(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .store_type(st),
        .eff_addr(ea), .rt_data(rt), .busy(busy1), .done(done1),
        .addr_err(aerr1), .timeout(tmo1), .bus(bus1.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] ea;
        logic [31:0] rt;
        logic        err;
        logic [31:0] ad;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic [31:0] ad;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    vec_t vecs[16];
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the bus against the oldest expected transfer.
    task automatic sb_pop(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk({tag, " address"}, bus0.address, e.ad);
            chk({tag, " byteenable"}, {28'd0, bus0.byteenable}, {28'd0, e.be});
            chk({tag, " writedata"}, bus0.writedata, e.wd);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        st = v.st; ea = v.ea; rt = v.rt; start0 = 1'b1;
        if (!v.err) sbq.push_back('{v.ad, v.be, v.wd});
        @(negedge clk);
        start0 = 1'b0;
        if (v.err) begin
            chk({tag, " addr_err"}, aerr0, 1'b1);
            chk({tag, " busy"}, busy0, 1'b1);
            chk({tag, " write"}, bus0.write, 1'b0);
            chk({tag, " done"}, done0, 1'b0);
            @(negedge clk);
            chk({tag, " addr_err_clr"}, aerr0, 1'b0);
            chk({tag, " busy_clr"}, busy0, 1'b0);
            chk({tag, " write_idle"}, bus0.write, 1'b0);
            chk({tag, " done_idle"}, done0, 1'b0);
        end else begin
            chk({tag, " write"}, bus0.write, 1'b1);
            chk({tag, " busy"}, busy0, 1'b1);
            chk({tag, " done_early"}, done0, 1'b0);
            sb_pop(tag);
            @(negedge clk);
            chk({tag, " done"}, done0, 1'b1);
            chk({tag, " write_drop"}, bus0.write, 1'b0);
            chk({tag, " busy_done"}, busy0, 1'b1);
            chk({tag, " excl"}, {aerr0, tmo0}, 2'b00);
            @(negedge clk);
            chk({tag, " done_clr"}, done0, 1'b0);
            chk({tag, " busy_clr"}, busy0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'd3, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF};
        vecs[1]  = '{3'd1, 32'h0000_2003, 32'h0000_00A5, 1'b0, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5};
        vecs[2]  = '{3'd2, 32'h0000_2002, 32'h0000_1234, 1'b0, 32'h0000_2000, 4'b1100, 32'h1234_1234};
        vecs[3]  = '{3'd4, 32'h0000_4001, 32'h1122_3344, 1'b0, 32'h0000_4000, 4'b0011, 32'h0000_1122};
        vecs[4]  = '{3'd5, 32'h0000_4001, 32'h1122_3344, 1'b0, 32'h0000_4000, 4'b1110, 32'h2233_4400};
        vecs[5]  = '{3'd2, 32'h0000_3001, 32'h0000_5555, 1'b1, 32'h0, 4'b0, 32'h0};
        vecs[6]  = '{3'd6, 32'h0000_3000, 32'h0000_5555, 1'b1, 32'h0, 4'b0, 32'h0};
        vecs[7]  = '{3'd0, 32'h0000_3000, 32'h0000_5555, 1'b1, 32'h0, 4'b0, 32'h0};
        vecs[8]  = '{3'd3, 32'h0000_5002, 32'h0000_5555, 1'b1, 32'h0, 4'b0, 32'h0};
        vecs[9]  = '{3'd1, 32'h0000_6001, 32'hFFFF_FF7F, 1'b0, 32'h0000_6000, 4'b0010, 32'h7F7F_7F7F};
        vecs[10] = '{3'd4, 32'h0000_7003, 32'h1122_3344, 1'b0, 32'h0000_7000, 4'b1111, 32'h1122_3344};
        vecs[11] = '{3'd4, 32'h0000_7000, 32'h1122_3344, 1'b0, 32'h0000_7000, 4'b0001, 32'h0000_0011};
        vecs[12] = '{3'd5, 32'h0000_7003, 32'h1122_3344, 1'b0, 32'h0000_7000, 4'b1000, 32'h4400_0000};
        vecs[13] = '{3'd5, 32'h0000_7000, 32'h1122_3344, 1'b0, 32'h0000_7000, 4'b1111, 32'h1122_3344};
        vecs[14] = '{3'd2, 32'h8000_0000, 32'hABCD_9876, 1'b0, 32'h8000_0000, 4'b0011, 32'h9876_9876};
        vecs[15] = '{3'd7, 32'h0000_9000, 32'h0000_0001, 1'b1, 32'h0, 4'b0, 32'h0};

        bus0.waitrequest = 1'b0;
        bus1.waitrequest = 1'b0;

        // Reset state
        #12;
        chk("rst busy", busy0, 1'b0);
        chk("rst done", done0, 1'b0);
        chk("rst addr_err", aerr0, 1'b0);
        chk("rst timeout", tmo0, 1'b0);
        chk("rst write", bus0.write, 1'b0);
        chk("rst address", bus0.address, 32'd0);
        chk("rst writedata", bus0.writedata, 32'd0);
        chk("rst byteenable", {28'd0, bus0.byteenable}, 32'd0);
        chk("rst write1", bus1.write, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Three stalled cycles with MAX_WAIT=0; a second start is ignored.
        bus0.waitrequest = 1'b1;
        @(negedge clk);
        st = 3'd3; ea = 32'h0000_9004; rt = 32'hCAFE_F00D; start0 = 1'b1;
        sbq.push_back('{32'h0000_9004, 4'b1111, 32'hCAFE_F00D});
        @(negedge clk);
        chk("stall write", bus0.write, 1'b1);
        sb_pop("stall");
        st = 3'd1; ea = 32'h0000_A001; rt = 32'h0000_0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d write", i), bus0.write, 1'b1);
            chk($sformatf("stall%0d address", i), bus0.address, 32'h0000_9004);
            chk($sformatf("stall%0d writedata", i), bus0.writedata, 32'hCAFE_F00D);
            chk($sformatf("stall%0d byteenable", i), {28'd0, bus0.byteenable}, 32'hF);
            chk($sformatf("stall%0d done", i), done0, 1'b0);
            chk($sformatf("stall%0d timeout", i), tmo0, 1'b0);
        end
        @(negedge clk);
        chk("stall2 write", bus0.write, 1'b1);
        chk("stall2 address", bus0.address, 32'h0000_9004);
        start0 = 1'b0;
        bus0.waitrequest = 1'b0;
        @(negedge clk);
        chk("stall done", done0, 1'b1);
        chk("stall write_drop", bus0.write, 1'b0);
        chk("stall hold address", bus0.address, 32'h0000_9004);
        chk("stall timeout", tmo0, 1'b0);
        @(negedge clk);
        chk("stall done_clr", done0, 1'b0);
        chk("stall busy_clr", busy0, 1'b0);
        chk("stall no_restart", bus0.write, 1'b0);

        // Timeout with MAX_WAIT=2
        bus1.waitrequest = 1'b1;
        @(negedge clk);
        st = 3'd3; ea = 32'h0000_B000; rt = 32'h0BAD_F00D; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("tmo write", bus1.write, 1'b1);
        chk("tmo busy", busy1, 1'b1);
        @(negedge clk);
        chk("tmo write2", bus1.write, 1'b1);
        chk("tmo early", tmo1, 1'b0);
        @(negedge clk);
        chk("tmo pulse", tmo1, 1'b1);
        chk("tmo write_drop", bus1.write, 1'b0);
        chk("tmo busy_drop", busy1, 1'b0);
        chk("tmo no_done", done1, 1'b0);
        chk("tmo no_aerr", aerr1, 1'b0);
        @(negedge clk);
        chk("tmo clr", tmo1, 1'b0);
        chk("tmo no_done2", done1, 1'b0);
        chk("tmo write_idle", bus1.write, 1'b0);
        bus1.waitrequest = 1'b0;

        // Reset in the middle of a stalled write
        bus0.waitrequest = 1'b1;
        @(negedge clk);
        st = 3'd3; ea = 32'h0000_C000; rt = 32'h1357_9BDF; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("mrst write_before", bus0.write, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mrst write", bus0.write, 1'b0);
        chk("mrst busy", busy0, 1'b0);
        chk("mrst done", done0, 1'b0);
        chk("mrst address", bus0.address, 32'd0);
        chk("mrst writedata", bus0.writedata, 32'd0);
        chk("mrst byteenable", {28'd0, bus0.byteenable}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus0.waitrequest = 1'b0;
        @(negedge clk);
        chk("mrst no_done", done0, 1'b0);
        chk("mrst idle", busy0, 1'b0);
        run_vec(vecs[4], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
